// File: rtl/div_pkg.sv
// Shared types and two's-complement helpers for the sequential restoring divider.
package div_pkg;

  // Widest operand the helpers below can handle; instances must not exceed it.
  localparam int MAX_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Callers zero-extend a WIDTH-bit value and keep the low WIDTH bits of the result.
  // Those low bits are exactly the WIDTH-bit two's-complement negation.
  function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] x);
    return (~x) + MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] twos_abs(input logic [MAX_WIDTH-1:0] x,
                                                    input logic              is_neg);
    return is_neg ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem < divisor, so trial < 2*divisor: the top bit of diff is exactly the borrow.
  assign trial    = {rem, next_bit};
  assign diff     = trial - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock,
// with start/busy/done handshake and divide-by-zero detection.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("seq_divider: WIDTH out of supported range");
  end

  state_t           state;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_work;
  logic             sign_q;
  logic             sign_r;

  logic             use_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign use_signed = SIGNED_EN & signed_mode;

  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  assign a_abs = WIDTH'(twos_abs(MAX_WIDTH'(a), use_signed & a[WIDTH-1]));
  assign b_abs = WIDTH'(twos_abs(MAX_WIDTH'(b), use_signed & b[WIDTH-1]));

  assign q_fix = sign_q ? WIDTH'(twos_neg(MAX_WIDTH'(q_work))) : q_work;
  assign r_fix = sign_r ? WIDTH'(twos_neg(MAX_WIDTH'(rem)))    : rem;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .next_bit(a_mag[bit_idx]),
    .divisor (b_mag),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // NOTE: every register, datapath included, takes the async reset so that an
  // aborted division leaves no stale operands; all state updates use <= so the
  // whole block reads pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      rem         <= '0;
      q_work      <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      q           <= '0;
      r           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            sign_q  <= use_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r  <= use_signed & a[WIDTH-1];
            rem     <= '0;
            q_work  <= '0;
            bit_idx <= CW'(WIDTH - 1);
            if (b == '0) begin
              // Zero divisor short-circuits straight to a result cycle.
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              q           <= '1;
              r           <= a;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          rem    <= rem_next;
          q_work <= {q_work[WIDTH-2:0], q_bit};
          if (bit_idx == '0) begin
            state <= FIX;
          end else begin
            bit_idx <= bit_idx - CW'(1);
          end
        end

        FIX: begin
          q     <= q_fix;
          r     <= r_fix;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: a 32-bit signed-capable instance and
// an 8-bit instance, all expected values computed by hand.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset;

  logic        start32, sm32;
  logic [31:0] a32, b32, q32, r32;
  logic        busy32, done32, dbz32;

  logic        start8, sm8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dbz8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
    .q(q32), .r(r32)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .q(q8), .r(r8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; drives start immediately and returns at the
  // falling edge where done is seen. lat counts rising edges from the one that
  // samples start up to the one that raises done.
  task automatic run32(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                       input int disturb, output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    a32 = av; b32 = bv; sm32 = sm; start32 = 1'b1;
    while (!seen && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 1) start32 = 1'b0;
      if (disturb != 0 && lat == disturb) begin
        start32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
      end
      if (disturb != 0 && lat == disturb + 1) start32 = 1'b0;
      if (busy32) bcnt++;
      if (done32) seen = 1'b1;
    end
    check("done32_seen", 64'(seen), 64'd1);
  endtask

  task automatic div32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sm, input int disturb,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int elat, input int ebusy);
    int lat, bcnt;
    run32(av, bv, sm, disturb, lat, bcnt);
    check({tag, ".q"},    64'(q32),   64'(eq));
    check({tag, ".r"},    64'(r32),   64'(er));
    check({tag, ".dbz"},  64'(dbz32), 64'(edz));
    check({tag, ".lat"},  64'(lat),   64'(elat));
    check({tag, ".busy"}, 64'(bcnt),  64'(ebusy));
  endtask

  task automatic div8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sm, input logic [7:0] eq, input logic [7:0] er,
                      input int elat);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
    while (!seen && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      start8 = 1'b0;
      if (done8) seen = 1'b1;
    end
    check({tag, ".seen"}, 64'(seen), 64'd1);
    check({tag, ".q"},    64'(q8),   64'(eq));
    check({tag, ".r"},    64'(r8),   64'(er));
    check({tag, ".lat"},  64'(lat),  64'(elat));
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("rst.busy", 64'(busy32), 64'd0);
    check("rst.done", 64'(done32), 64'd0);
    check("rst.dbz",  64'(dbz32),  64'd0);
    check("rst.q",    64'(q32),    64'd0);
    check("rst.r",    64'(r32),    64'd0);

    div32("u100_7", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 34, 33);
    div32("s-7_2",  32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
    div32("s7_-2",  32'd7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 33);
    div32("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 33);

    repeat (2) @(negedge clock);
    div32("dbz", 32'h1234_5678, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1, 0);
    @(negedge clock);
    check("dbz.pulse", 64'(done32), 64'd0);
    check("dbz.held",  64'(dbz32),  64'd1);

    div32("dbz_clr", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 34, 33);
    div32("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 34, 33);
    div32("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'h8000_0000, 1'b0, 34, 33);

    @(negedge clock);
    div32("ignore", 32'd1000, 32'd3, 1'b0, 5, 32'd333, 32'd1, 1'b0, 34, 33);
    div32("b2b",    32'hFFFF_FFFF, 32'h10, 1'b0, 0, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, 33);

    // Abort a division at its tenth cycle; previous nonzero q/r must clear.
    a32 = 32'd100; b32 = 32'd7; sm32 = 1'b0; start32 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      @(negedge clock);
      start32 = 1'b0;
    end
    check("abort.busy_pre", 64'(busy32), 64'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(busy32), 64'd0);
    check("abort.done", 64'(done32), 64'd0);
    check("abort.q",    64'(q32),    64'd0);
    check("abort.r",    64'(r32),    64'd0);
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done32 || busy32) done_cnt++;
    end
    check("abort.quiet", 64'(done_cnt), 64'd0);

    div8("w8_255_16", 8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 10);
    div8("w8_s-128_3", 8'h80, 8'd3, 1'b1, 8'hD6, 8'hFE, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider, one quotient bit per clock (restoring algorithm), with signed/unsigned mode, start/busy/done handshake and divide-by-zero detection. Sits beside the ALU as the long-latency divide unit; the controller issues a start pulse, stalls on busy, and consumes q/r on done. It is the next-generation replacement for the fixed 32-bit unsigned divider, which has no reset, no handshake and no zero check.

## Interface

- WIDTH, 32, operand/result width in bits (≥ 4)
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  input  1  request; sampled only when busy = 0
- signed_mode  input  1  1 = two's-complement operands, sampled with start
- a  input  WIDTH  dividend, sampled with start
- b  input  WIDTH  divisor, sampled with start
- busy  output  1  operation in progress (CALC or FIX)
- done  output  1  one-cycle pulse; q, r, div_by_zero valid in that cycle
- div_by_zero  output  1  set with done when latched b = 0
- q  output  WIDTH  quotient, held until next accepted start
- r  output  WIDTH  remainder, held until next accepted start

## Operation

- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: latch operands and mode; if b = 0 → DONE with q = all ones, r = a, div_by_zero = 1; else → CALC, bit index i = WIDTH-1, partial remainder = 0.
- Signed mode: iterate on magnitudes |a|, |b| (WIDTH-bit unsigned; |MIN| = 2^(WIDTH-1) fits). Record sign_q = a[MSB]^b[MSB], sign_r = a[MSB].
- CALC, per cycle: t = {rem, a_mag[i]} (WIDTH+1 bits, no truncation); if t ≥ b_mag then q[i] = 1, rem = t − b_mag else q[i] = 0, rem = t; i−1. After i = 0 step → FIX.
- FIX: negate q if sign_q, negate r if sign_r (signed only); → DONE.
- DONE: done = 1 for exactly this cycle; → IDLE unless start, which is accepted here (back-to-back).
- Results: truncation toward zero; remainder carries sign of dividend; a = q·b + r always holds for b ≠ 0.
- Overflow MIN / −1 (signed): q = MIN (wraps), r = 0, div_by_zero = 0, no extra flag.
- start while busy: ignored, no effect on operands or state.
- div_by_zero cleared on next accepted start.

## Timing

- Reset values: busy = 0, done = 0, div_by_zero = 0, q = 0, r = 0, state IDLE.
- Normal latency: start sampled at edge N → busy high from N; done high in cycle after edge N+WIDTH+1 (WIDTH CALC + 1 FIX); busy low in the done cycle.
- Divide-by-zero latency: done high in cycle after edge N; busy never asserted.
- Throughput: one division per WIDTH+2 cycles with back-to-back start in the DONE cycle.
- q/r change only at the transition into DONE; stable otherwise (intermediate q bits kept internal).
- reset asserted mid-operation: immediate return to IDLE, outputs to reset values, no done pulse.

## Structure

- Package div_pkg: state enum (IDLE, CALC, FIX, DONE), two's-complement abs/negate functions, width-parametrised.
- Sub-module div_step: combinational single restoring step (rem, next dividend bit, divisor → new rem, quotient bit); instantiated once in the datapath.
- Top: FSM, operand/sign registers, log2(WIDTH) bit counter, q/r output registers.

## Test plan

- WIDTH=32, unsigned, a=100, b=7 → q=14, r=2, done exactly 34 cycles after start, busy high 33 cycles.
- Signed, a=−7, b=2 → q=−3 (0xFFFFFFFD), r=−1 (0xFFFFFFFF); a=7, b=−2 → q=−3, r=1.
- b=0, a=0x12345678 → done next cycle, div_by_zero=1, q=0xFFFFFFFF, r=0x12345678, busy never high.
- Signed a=0x80000000, b=−1 → q=0x80000000, r=0; unsigned same operands → q=0, r=0x80000000.
- start pulsed with new operands mid-CALC → ignored, original result returned; start in DONE cycle → second result after another 34 cycles.
- reset at cycle 10 of a division → busy/done/q/r = 0 immediately, no done; WIDTH=8 build: 255/16 unsigned → q=15, r=15, latency 10.
